// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall detection.
// Tracks {valid, wb_en, mem_read, dest} for the DEPTH stages below ID and, per
// source operand, selects the youngest in-flight writer (0 = register file).
// Optional build macro FWD_ZERO_REG_FILTER_EN: register 0 never forwards.
module fwd_hazard_unit #(
  parameter  int NSRC             = 3,
  parameter  int REG_AW           = 5,
  parameter  int DEPTH            = 3,
  parameter  int LOAD_READY_STAGE = 2,
  localparam int SELW             = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*REG_AW-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]      id_dest,
  input  logic                   id_wb_en,
  input  logic                   id_mem_read,
  input  logic                   flush,
  input  logic                   freeze,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   stall,
  output logic [15:0]            stall_cnt
);

  // Stage history, index 1 = EXE (youngest) .. DEPTH (oldest).
  logic [DEPTH:1]    valid_q, valid_d;
  logic [DEPTH:1]    wb_q, wb_d;
  logic [DEPTH:1]    mr_q, mr_d;
  logic [REG_AW-1:0] dest_q [1:DEPTH];
  logic [REG_AW-1:0] dest_d [1:DEPTH];
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic [DEPTH:1]    hit_m [NSRC];
  logic [SELW-1:0]   sel_a [NSRC];
  logic [NSRC-1:0]   haz_s;
  logic              stall_s;
  logic              insert_s;

  // A stage supplies a source when it holds a live write to that register.
  function automatic logic src_hit(input logic vld, input logic wb,
                                   input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] src,
                                   input logic used);
    logic hit;
    hit = vld & wb & used & (dst == src);
`ifdef FWD_ZERO_REG_FILTER_EN
    hit = hit & (src != {REG_AW{1'b0}});
`endif
    return hit;
  endfunction

  // Match matrix: every source against every tracked stage.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      hit_m[i] = '0;
      for (int k = 1; k <= DEPTH; k++) begin
        hit_m[i][k] = src_hit(valid_q[k], wb_q[k], dest_q[k],
                              id_src[i*REG_AW +: REG_AW], id_src_used[i]);
      end
    end
  end

  // Priority pick: scanning oldest to youngest lets the youngest writer win.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      sel_a[i] = '0;
      haz_s[i] = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        sel_a[i] = hit_m[i][k] ? SELW'(k) : sel_a[i];
        haz_s[i] = hit_m[i][k] ? (mr_q[k] & (k < LOAD_READY_STAGE)) : haz_s[i];
      end
    end
  end

  assign stall_s  = id_valid & (|haz_s);
  assign insert_s = id_valid & ~stall_s & ~flush;

  // Next history: shift one stage unless frozen; stall/flush inject a bubble.
  always_comb begin
    valid_d     = valid_q;
    wb_d        = wb_q;
    mr_d        = mr_q;
    dest_d      = dest_q;
    stall_cnt_d = stall_cnt_q;
    if (!freeze) begin
      for (int k = DEPTH; k >= 2; k--) begin
        valid_d[k] = valid_q[k-1];
        wb_d[k]    = wb_q[k-1];
        mr_d[k]    = mr_q[k-1];
        dest_d[k]  = dest_q[k-1];
      end
      valid_d[1] = insert_s;
      wb_d[1]    = insert_s & id_wb_en;
      mr_d[1]    = insert_s & id_mem_read;
      dest_d[1]  = id_dest;
      if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // History and stall counter registers; reset clears them immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= '0;
      wb_q        <= '0;
      mr_q        <= '0;
      stall_cnt_q <= 16'd0;
      for (int k = 1; k <= DEPTH; k++) begin
        dest_q[k] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      wb_q        <= wb_d;
      mr_q        <= mr_d;
      stall_cnt_q <= stall_cnt_d;
      for (int k = 1; k <= DEPTH; k++) begin
        dest_q[k] <= dest_d[k];
      end
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_sel
    assign fwd_sel[g*SELW +: SELW] = sel_a[g];
  end

  assign stall     = stall_s;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios then random
// traffic, compared against a queue-based model of the pipeline history.
module tb_fwd_hazard_unit;
  localparam int NSRC = 3;
  localparam int REG_AW = 5;
  localparam int DEPTH = 3;
  localparam int LRS = 2;
  localparam int SELW = 2;
`ifdef FWD_ZERO_REG_FILTER_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [NSRC*REG_AW-1:0] id_src;
  logic [NSRC-1:0] id_src_used;
  logic [REG_AW-1:0] id_dest;
  logic id_wb_en, id_mem_read, flush, freeze;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic stall;
  logic [15:0] stall_cnt;

  fwd_hazard_unit #(.NSRC(NSRC), .REG_AW(REG_AW), .DEPTH(DEPTH), .LOAD_READY_STAGE(LRS)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .flush(flush), .freeze(freeze),
    .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {bit v; bit wb; bit mr; bit [REG_AW-1:0] d;} ent_t;
  ent_t hist [$];            // hist[0] = stage 1 (youngest)
  int unsigned mcnt;
  int errors = 0;
  int checks = 0;
  logic [NSRC*SELW-1:0] exp_sel;
  logic exp_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ent_t e;
    e = '0;
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(e);
    mcnt = 0;
  endtask

  // Expected outputs: first (youngest) stage writing the source register.
  function automatic void model_eval();
    int found;
    logic [REG_AW-1:0] s;
    exp_sel = '0;
    exp_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      found = 0;
      s = id_src[i*REG_AW +: REG_AW];
      if (id_src_used[i] && !(ZF && s == 0)) begin
        for (int k = 1; k <= DEPTH; k++) begin
          if (found == 0 && hist[k-1].v && hist[k-1].wb && hist[k-1].d == s) found = k;
        end
      end
      exp_sel[i*SELW +: SELW] = found[SELW-1:0];
      if (found != 0 && id_valid && hist[found-1].mr && found < LRS) exp_stall = 1'b1;
    end
  endfunction

  task automatic model_clock();
    ent_t e;
    if (!freeze) begin
      if (exp_stall && mcnt < 65535) mcnt++;
      e.v = id_valid && !exp_stall && !flush;
      e.wb = id_wb_en;
      e.mr = id_mem_read;
      e.d = id_dest;
      hist.push_front(e);
      void'(hist.pop_back());
    end
  endtask

  task automatic drv(input bit v, input int s0, input int s1, input int s2,
                     input bit [2:0] used, input int dst, input bit wb, input bit mr,
                     input bit fl, input bit fz);
    logic [REG_AW-1:0] a0, a1, a2, ad;
    a0 = s0[REG_AW-1:0]; a1 = s1[REG_AW-1:0]; a2 = s2[REG_AW-1:0]; ad = dst[REG_AW-1:0];
    id_valid = v; id_src = {a2, a1, a0}; id_src_used = used; id_dest = ad;
    id_wb_en = wb; id_mem_read = mr; flush = fl; freeze = fz;
  endtask

  task automatic eval_now(input string tag);
    #1;
    model_eval();
    check({tag, ".sel"}, 32'(fwd_sel), 32'(exp_sel));
    check({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    check({tag, ".cnt"}, 32'(stall_cnt), mcnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    drv(1, 5, 5, 5, 3'b111, 5, 1, 1, 0, 0);
    repeat (2) @(negedge clk);
    eval_now("reset");
    check("reset_sel0", 32'(fwd_sel), 32'd0);
    rst = 1'b1;

    // ALU writer of r5, then readers at distance 1..4
    drv(1, 1, 2, 3, 3'b000, 5, 1, 0, 0, 0); eval_now("w5"); tick();
    for (int d = 1; d <= 4; d++) begin
      drv(1, 5, 2, 3, 3'b001, 6, 0, 0, 0, 0);
      eval_now("dist");
      check($sformatf("dist%0d_src0", d), 32'(fwd_sel[1:0]), (d == 4) ? 32'd0 : 32'(d));
      check($sformatf("dist%0d_stall", d), 32'(stall), 32'd0);
      tick();
    end

    // Two writers of r9; youngest wins
    drv(1, 0, 0, 0, 3'b000, 9, 1, 0, 0, 0); eval_now("w9a"); tick();
    drv(1, 0, 0, 0, 3'b000, 9, 1, 0, 0, 0); eval_now("w9b"); tick();
    drv(1, 4, 9, 4, 3'b010, 6, 0, 0, 0, 0); eval_now("r9");
    check("r9_src1", 32'(fwd_sel[3:2]), 32'd1); tick();

    // Load r7 then use: one stall, then forward from stage 2
    drv(1, 0, 0, 0, 3'b000, 7, 1, 1, 0, 0); eval_now("ld7"); tick();
    drv(1, 1, 1, 7, 3'b100, 8, 0, 0, 0, 0); eval_now("use7a");
    check("use7_stall", 32'(stall), 32'd1); tick();
    eval_now("use7b");
    check("use7_src2", 32'(fwd_sel[5:4]), 32'd2);
    check("use7_nostall", 32'(stall), 32'd0);
    check("use7_cnt", 32'(stall_cnt), 32'd1); tick();

    // Load-use stall held under freeze
    drv(1, 0, 0, 0, 3'b000, 7, 1, 1, 0, 0); eval_now("ld7f"); tick();
    for (int c = 0; c < 3; c++) begin
      drv(1, 1, 1, 7, 3'b100, 8, 0, 0, 0, 1); eval_now("frz");
      check("frz_stall", 32'(stall), 32'd1);
      check("frz_cnt", 32'(stall_cnt), 32'd1); tick();
    end
    drv(1, 1, 1, 7, 3'b100, 8, 0, 0, 0, 0); eval_now("unfrz"); tick();
    eval_now("unfrz2");
    check("unfrz_cnt", 32'(stall_cnt), 32'd2); tick();

    // Register 0 writer then reader
    drv(1, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0); eval_now("w0"); tick();
    drv(1, 0, 3, 3, 3'b001, 6, 0, 0, 0, 0); eval_now("r0");
    check("r0_src0", 32'(fwd_sel[1:0]), ZF ? 32'd0 : 32'd1); tick();

    // Build stall_cnt to 4, then reset mid-stall
    drv(1, 0, 0, 0, 3'b000, 3, 1, 1, 0, 0); eval_now("ld3"); tick();
    drv(1, 3, 0, 0, 3'b001, 6, 0, 0, 0, 0); eval_now("u3"); tick();
    eval_now("u3b"); tick();
    drv(1, 0, 0, 0, 3'b000, 4, 1, 1, 0, 0); eval_now("ld4"); tick();
    drv(1, 4, 0, 0, 3'b001, 6, 0, 0, 0, 0); eval_now("u4"); tick();
    drv(1, 0, 0, 0, 3'b000, 11, 1, 1, 0, 0); eval_now("ld11"); tick();
    drv(1, 0, 11, 0, 3'b010, 6, 0, 0, 0, 0); eval_now("u11");
    check("pre_rst_stall", 32'(stall), 32'd1);
    check("pre_rst_cnt", 32'(stall_cnt), 32'd4);
    #2 rst = 1'b0;
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel", 32'(fwd_sel), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Random traffic with flush/freeze against the model
    for (int n = 0; n < 400; n++) begin
      drv(($urandom % 4) != 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
          3'($urandom), $urandom_range(0, 7), 1'($urandom), 1'($urandom),
          ($urandom % 8) == 0, ($urandom % 8) == 0);
      eval_now("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
